mux_sync_tx: RTL and testbench
==============================

# mux_sync_tx

Source-domain sender for the mux-recirculation synchronizer path. Accepts words over a valid/ready handshake, presents each word on a held bus with a toggle request, and will not change the bus until the destination's toggle acknowledge has returned through an internal N-flop synchronizer and a guard interval has elapsed. It sits in the transmitting clock domain. Its counterpart is the destination-side capture logic, which loads `tx_data` when it sees `tx_req` change.

## Interface
- `DW`, 8: data width.
- `SYNC_STAGES`, 2: flops in the `rx_ack` synchronizer; legal range is 2 or more.
- `GUARD`, 2: cycles `tx_data` stays held after the acknowledge matches; 0 is legal.
- `TO_CYCLES`, 255: acknowledge timeout in cycles; legal range is 1 or more. Used only with `MUX_SYNC_TX_TIMEOUT_EN`.

- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_data` in DW: word to send.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block can accept a word.
- `tx_data` out DW: held bus toward the destination domain.
- `tx_req` out 1: request toggle; each change marks one new word.
- `rx_ack` in 1: acknowledge toggle from the destination domain; asynchronous to `clk`.
- `busy` out 1: state is not IDLE.
- `err` out 1: sticky acknowledge-timeout flag.

## Operation
- Reset values: state IDLE, `tx_data` 0, `tx_req` 0, synchronizer flops 0, counters 0, `err` 0. `in_ready` is therefore 1 out of reset.
- `rx_ack` passes through `SYNC_STAGES` flops; the last stage is `ack_s`. Nothing else samples `rx_ack`.
- `in_ready` is 1 exactly when state is IDLE. It is decoded from the registered state.
- State machine:
  - **IDLE**: when `in_valid` is 1, register `in_data` into `tx_data` and go to SETUP.
  - **SETUP**: one cycle. Toggle `tx_req` and go to WAIT. This guarantees the data bus is stable one full cycle before the request edge.
  - **WAIT**: when `ack_s` equals `tx_req`, either load the guard counter with `GUARD-1` and go to GUARD, or go to IDLE if `GUARD` is 0.
  - **GUARD**: decrement the counter each cycle; at 0, go to IDLE.
  - **FAULT** (exists only with the macro): see Configuration.
- `tx_data` changes only on the IDLE accept edge. `tx_req` changes only on the SETUP exit edge.
- An `rx_ack` change while not in WAIT is ignored; it is still synchronized and compared on the next WAIT.
- `busy` is the inverse of `in_ready`.
- Reset mid-transfer: all state returns to reset values immediately. The destination must be reset together with this block so that the two toggles realign.

## Timing
- Accept edge A: `in_valid` and `in_ready` are both 1.
- `tx_data` holds the new word after A.
- `tx_req` toggles one edge later, at A+1.
- Edge E is the `rx_ack` toggle. With a synchronous bench, `ack_s` matches at E+`SYNC_STAGES`.
- If `GUARD` is 0, `in_ready` rises after the same edge where the match is seen.
- If `GUARD` is 1 or more, `in_ready` rises `GUARD` edges after the match.
- Minimum word period is 2 + `SYNC_STAGES` + `GUARD` + (destination round-trip) cycles.
- Back-to-back words: `in_valid` held high is accepted on the first IDLE cycle after GUARD ends.

## Configuration
- Macro: `MUX_SYNC_TX_TIMEOUT_EN`.
- **Defined**:
  - A WAIT-cycle counter clears on WAIT entry and increments each WAIT cycle.
  - If it reaches `TO_CYCLES` without an acknowledge match, set `err` and enter FAULT.
  - In FAULT, `in_ready` is 0 and `tx_data` and `tx_req` hold; only `rst` exits.
- **Undefined**: no counter and no FAULT state. `err` is tied to 0 and WAIT waits indefinitely.

## Structure
- Shared package `mux_sync_pkg`: the state enum (IDLE, SETUP, WAIT, GUARD, FAULT) and `SYNC_MIN` = 2, which is checked against `SYNC_STAGES` at elaboration.
- One sub-module, `sync_ndff`: a parameterized N-stage single-bit synchronizer instantiated for `rx_ack`. It takes `clk` and `rst`, and resets to 0.
- Target implementation size: 150–250 lines total.

## Test plan
1. **Reset**: assert `rst` mid-WAIT with `tx_data`=8'hA5 → `tx_data`=0, `tx_req`=0, `in_ready`=1, `busy`=0, and `err`=0 while `rst` is still high.
2. **Single word**: send 8'h3C with defaults and a bench ack 3 cycles after the `tx_req` toggle → `tx_data`=8'h3C at A, `tx_req`=1 at A+1, `in_ready`=1 at A+1+3+2+2.
3. **Back-to-back**: hold `in_valid` with 8'h01 then 8'h02 → exactly two `tx_req` toggles, and `tx_data` never changes between A and the guard end.
4. **Stray ack**: toggle `rx_ack` while IDLE, then send 8'h55 → the transfer completes only on the next genuine toggle, with no premature `in_ready`.
5. **GUARD=0, SYNC_STAGES=3**: `in_ready` returns on the same edge that `ack_s` matches, 3 cycles after the ack edge.
6. **Timeout (macro defined, `TO_CYCLES`=16)**: never ack → `err`=1 after 16 WAIT cycles, `in_ready` stays 0 indefinitely, and `rst` clears both.

Source files
------------

// File: rtl/mux_sync_pkg.sv
// Shared definitions for the mux-recirculation synchronizer sender.
//
// Contents:
//   state_e  - sender state machine encoding
//   SYNC_MIN - smallest legal synchronizer depth
package mux_sync_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StWait,
    StGuard,
    StFault
  } state_e;

  localparam int unsigned SYNC_MIN = 2;

endpackage

// File: rtl/sync_ndff.sv
// N-stage single-bit synchronizer. Every flop resets to 0.
//
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset
//   d   - asynchronous input bit
//   q   - synchronized output (last stage)
module sync_ndff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d};
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/mux_sync_tx.sv
// Source-domain sender for the mux-recirculation synchronizer path.
// A word taken over valid/ready is held on tx_data; one cycle later tx_req
// toggles. The bus is not released until the synchronized acknowledge
// matches tx_req and GUARD further cycles have passed.
//
// Optional feature macro: MUX_SYNC_TX_TIMEOUT_EN
//   defined   - acknowledge timeout of TO_CYCLES WAIT cycles; on expiry err
//               is set and the block parks in FAULT until rst.
//   undefined - no timeout, err tied to 0, WAIT waits indefinitely.
//
// Ports:
//   clk      - sole clock
//   rst      - asynchronous active-high reset
//   in_data  - word to send
//   in_valid - in_data is valid
//   in_ready - block can accept a word (state is IDLE)
//   tx_data  - held bus toward the destination domain
//   tx_req   - request toggle, one change per word
//   rx_ack   - acknowledge toggle from the destination (asynchronous)
//   busy     - state is not IDLE
//   err      - sticky acknowledge-timeout flag
module mux_sync_tx
  import mux_sync_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GUARD       = 2,
  parameter int unsigned TO_CYCLES   = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] tx_data,
  output logic          tx_req,
  input  logic          rx_ack,
  output logic          busy,
  output logic          err
);

  generate
    if (SYNC_STAGES < SYNC_MIN) begin : gen_sync_check
      $error("mux_sync_tx: SYNC_STAGES must be at least SYNC_MIN");
    end
  endgenerate

  localparam int unsigned GuardW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [GuardW-1:0] GuardLoad = GuardW'((GUARD > 0) ? GUARD - 1 : 0);

  state_e            state_q;
  logic [DW-1:0]     tx_data_q;
  logic              tx_req_q;
  logic [GuardW-1:0] guard_cnt_q;
  logic              ack_s;

`ifdef MUX_SYNC_TX_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TO_CYCLES + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TO_CYCLES - 1);

  logic [ToW-1:0] wait_cnt_q;
  logic           err_q;
`else
  logic unused_to_cycles;
  assign unused_to_cycles = ^TO_CYCLES;
`endif

  sync_ndff #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx_ack),
    .q  (ack_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tx_data_q   <= '0;
      tx_req_q    <= 1'b0;
      guard_cnt_q <= '0;
`ifdef MUX_SYNC_TX_TIMEOUT_EN
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            tx_data_q <= in_data;
            state_q   <= StSetup;
          end
        end
        // Data has been stable for one full cycle before the request edge.
        StSetup: begin
          tx_req_q <= ~tx_req_q;
          state_q  <= StWait;
`ifdef MUX_SYNC_TX_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        StWait: begin
          if (ack_s == tx_req_q) begin
            if (GUARD == 0) begin
              state_q <= StIdle;
            end else begin
              guard_cnt_q <= GuardLoad;
              state_q     <= StGuard;
            end
          end
`ifdef MUX_SYNC_TX_TIMEOUT_EN
          else if (wait_cnt_q == ToLast) begin
            err_q   <= 1'b1;
            state_q <= StFault;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        StGuard: begin
          if (guard_cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            guard_cnt_q <= guard_cnt_q - 1'b1;
          end
        end
`ifdef MUX_SYNC_TX_TIMEOUT_EN
        // Parked until rst; bus and request hold.
        StFault: begin
          state_q <= StFault;
        end
`endif
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready = (state_q == StIdle);
  assign busy     = ~in_ready;
  assign tx_data  = tx_data_q;
  assign tx_req   = tx_req_q;

`ifdef MUX_SYNC_TX_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_sync_tx.sv
`timescale 1ns/1ps
module tb_mux_sync_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data,  in_data5;
  logic       in_valid, in_valid5;
  logic       in_ready, in_ready5;
  logic [7:0] tx_data,  tx_data5;
  logic       tx_req,   tx_req5;
  logic       rx_ack,   rx_ack5;
  logic       busy,     busy5;
  logic       err,      err5;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic       last_req = 1'b0;

  always #5 clk = ~clk;

  mux_sync_tx #(
    .DW(8), .SYNC_STAGES(2), .GUARD(2), .TO_CYCLES(16)
  ) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_data(tx_data), .tx_req(tx_req), .rx_ack(rx_ack), .busy(busy), .err(err)
  );

  mux_sync_tx #(
    .DW(8), .SYNC_STAGES(3), .GUARD(0), .TO_CYCLES(16)
  ) u_dut5 (
    .clk(clk), .rst(rst), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .tx_data(tx_data5), .tx_req(tx_req5), .rx_ack(rx_ack5), .busy(busy5), .err(err5)
  );

  // Scoreboard: every tx_req change must present the next expected word.
  always @(posedge clk) begin
    #1;
    if (rst === 1'b1) begin
      exp_q.delete();
    end else if (tx_req !== last_req) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: tx_req toggled with tx_data=%h, no word queued", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data !== mon_exp) begin
          bad++;
          $display("FAIL sb_data: tx_data=%h expected=%h", tx_data, mon_exp);
        end
      end
    end
    last_req = tx_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_data = '0; in_valid = 1'b0; rx_ack = 1'b0;
    in_data5 = '0; in_valid5 = 1'b0; rx_ack5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({tx_data, tx_req, in_ready, busy, err} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_initial: data=%h req=%b rdy=%b busy=%b err=%b expected 00 0 1 0 0",
               tx_data, tx_req, in_ready, busy, err);
    end
    #2 rst = 1'b0;
    step();
    // Drive into WAIT with A5 and never acknowledge.
    exp_q.push_back(8'hA5);
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    total++;
    if (busy !== 1'b1 || tx_data !== 8'hA5) begin
      bad++;
      $display("FAIL reset_prewait: busy=%b data=%h expected 1 a5", busy, tx_data);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (tx_data !== 8'h00) begin
      bad++; $display("FAIL reset_mid_data: tx_data=%h expected=00", tx_data);
    end
    total++;
    if (tx_req !== 1'b0) begin
      bad++; $display("FAIL reset_mid_req: tx_req=%b expected=0", tx_req);
    end
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_rdy: in_ready=%b busy=%b expected 1 0", in_ready, busy);
    end
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL reset_mid_err: err=%b expected=0", err);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic early;
    early = 1'b0;
    exp_q.push_back(8'h3C);
    in_data = 8'h3C; in_valid = 1'b1;
    step();  // A
    in_valid = 1'b0;
    total++;
    if (tx_data !== 8'h3C || in_ready !== 1'b0) begin
      bad++; $display("FAIL single_accept: data=%h rdy=%b expected 3c 0", tx_data, in_ready);
    end
    step();  // A+1
    total++;
    if (tx_req !== 1'b1) begin
      bad++; $display("FAIL single_req: tx_req=%b expected=1", tx_req);
    end
    repeat (2) step();  // A+3; ack sampled at A+4
    rx_ack = 1'b1;
    for (int i = 4; i <= 7; i++) begin
      step();
      if (in_ready !== 1'b0) early = 1'b1;
    end
    total++;
    if (early) begin
      bad++; $display("FAIL single_early: in_ready rose before A+8, expected 0 until A+8");
    end
    step();  // A+8
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL single_done: in_ready=%b at A+8 expected=1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int         acc, toggles, ack_wait, gap;
    logic       rdy, stable, done, prev_req;
    logic [7:0] held;
    acc = 0; toggles = 0; ack_wait = 0; gap = 0;
    stable = 1'b1; done = 1'b0; held = tx_data; prev_req = tx_req;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    in_data = 8'h01; in_valid = 1'b1;
    for (int c = 0; c < 80 && !done; c++) begin
      rdy = in_ready;
      step();
      if (rdy && in_valid) begin
        acc++;
        held = tx_data;
        if (acc == 1) in_data = 8'h02;
        else in_valid = 1'b0;
      end else if (busy && tx_data !== held) begin
        stable = 1'b0;
      end
      if (acc == 1 && in_ready === 1'b1) gap++;
      if (tx_req !== prev_req) begin
        toggles++;
        prev_req = tx_req;
        ack_wait = 2;
      end else if (ack_wait > 0) begin
        ack_wait--;
        if (ack_wait == 0) rx_ack = tx_req;
      end
      if (acc == 2 && in_ready === 1'b1 && ack_wait == 0) done = 1'b1;
    end
    in_valid = 1'b0;
    total++;
    if (!done) begin
      bad++; $display("FAIL b2b_timeout: accepted=%0d expected 2 words done", acc);
    end
    total++;
    if (toggles != 2) begin
      bad++; $display("FAIL b2b_toggles: toggles=%0d expected=2", toggles);
    end
    total++;
    if (!stable) begin
      bad++; $display("FAIL b2b_stable: tx_data changed while busy, expected held");
    end
    total++;
    if (gap != 1) begin
      bad++; $display("FAIL b2b_gap: idle cycles between words=%0d expected=1", gap);
    end
  endtask

  task automatic test_stray_ack();
    logic early;
    int   n;
    early = 1'b0;
    n = 0;
    // Stray pulse while IDLE; net level returns to matching.
    rx_ack = ~rx_ack;
    repeat (3) step();
    rx_ack = ~rx_ack;
    repeat (3) step();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL stray_idle: in_ready=%b expected=1", in_ready);
    end
    exp_q.push_back(8'h55);
    in_data = 8'h55; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    repeat (8) begin
      step();
      if (in_ready !== 1'b0) early = 1'b1;
    end
    total++;
    if (early) begin
      bad++; $display("FAIL stray_premature: in_ready rose before genuine ack, expected 0");
    end
    rx_ack = tx_req;
    while (n < 12 && in_ready !== 1'b1) begin
      step();
      n++;
    end
    total++;
    if (n != 5) begin
      bad++; $display("FAIL stray_latency: cycles to ready=%0d expected=5", n);
    end
  endtask

  task automatic test_guard0();
    logic early;
    early = 1'b0;
    in_data5 = 8'hC3; in_valid5 = 1'b1;
    step();  // A
    in_valid5 = 1'b0;
    total++;
    if (tx_data5 !== 8'hC3) begin
      bad++; $display("FAIL g0_data: tx_data=%h expected=c3", tx_data5);
    end
    step();  // A+1
    total++;
    if (tx_req5 !== 1'b1) begin
      bad++; $display("FAIL g0_req: tx_req=%b expected=1", tx_req5);
    end
    rx_ack5 = 1'b1;  // ack edge E = A+2
    for (int i = 0; i < 3; i++) begin
      step();
      if (in_ready5 !== 1'b0) early = 1'b1;
    end
    total++;
    if (early) begin
      bad++; $display("FAIL g0_early: in_ready rose before E+3, expected 0");
    end
    step();  // E+3
    total++;
    if (in_ready5 !== 1'b1 || tx_data5 !== 8'hC3) begin
      bad++; $display("FAIL g0_done: rdy=%b data=%h expected 1 c3", in_ready5, tx_data5);
    end
  endtask

  task automatic test_timeout();
    logic       early, held_ok;
    logic       req_exp;
    early = 1'b0;
    held_ok = 1'b1;
    req_exp = ~tx_req;
    exp_q.push_back(8'h77);
    in_data = 8'h77; in_valid = 1'b1;
    step();  // A
    in_valid = 1'b0;
`ifdef MUX_SYNC_TX_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      step();
      if (err !== 1'b0) early = 1'b1;
    end
    total++;
    if (early) begin
      bad++; $display("FAIL to_early: err set before 16 WAIT cycles, expected 0");
    end
    step();  // A+17
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL to_err: err=%b expected=1", err);
    end
    repeat (20) begin
      step();
      if (in_ready !== 1'b0 || tx_data !== 8'h77 || tx_req !== req_exp) held_ok = 1'b0;
    end
    rx_ack = tx_req;
    repeat (6) begin
      step();
      if (in_ready !== 1'b0 || err !== 1'b1) held_ok = 1'b0;
    end
    total++;
    if (!held_ok) begin
      bad++; $display("FAIL to_fault_hold: FAULT not held (rdy/data/req/err), expected parked");
    end
`else
    repeat (40) begin
      step();
      if (err !== 1'b0) early = 1'b1;
      if (in_ready !== 1'b0 || tx_data !== 8'h77 || tx_req !== req_exp) held_ok = 1'b0;
    end
    total++;
    if (early) begin
      bad++; $display("FAIL to_err_tied: err went high, expected 0 without timeout");
    end
    total++;
    if (!held_ok) begin
      bad++; $display("FAIL to_wait_hold: WAIT did not hold, expected indefinite wait");
    end
`endif
    #2 rst = 1'b1;
    rx_ack = 1'b0;
    #1;
    total++;
    if (err !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL to_reset: err=%b rdy=%b expected 0 1", err, in_ready);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stray_ack();
    test_guard0();
    test_timeout();
    repeat (2) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover: %0d words never presented, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
